// File: rtl/line_raster_pkg.sv
// line_raster_pkg: FSM encoding and width helpers shared by the line rasteriser files.
package line_raster_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;
  function automatic int dw_of(input int w);
    return w + 1;
  endfunction
  function automatic int ew_of(input int w);
    return w + 2;
  endfunction
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/line_frag_addr.sv
// line_frag_addr: pixel coordinate to framebuffer address plus bounds test.
// Clipping is enabled by defining LINE_CLIP_EN; otherwise every pixel is in bounds and the address wraps.
module line_frag_addr
  import line_raster_pkg::*;
#(
  parameter int WIDTH  = 13,
  parameter int FB_W   = 640,
  parameter int FB_H   = 480,
  parameter int ADDR_W = 19
) (
  input  logic signed [WIDTH-1:0]  x,
  input  logic signed [WIDTH-1:0]  y,
  output logic        [ADDR_W-1:0] addr,
  output logic                     in_bounds
);
  if (ADDR_W < clog2(FB_W * FB_H)) begin : g_addr_chk
    $error("line_frag_addr: ADDR_W cannot hold FB_W*FB_H-1");
  end
  // Modular arithmetic at ADDR_W bits gives the two's-complement wrap for off-screen pixels.
  assign addr = ADDR_W'(y) * ADDR_W'(FB_W) + ADDR_W'(x);
`ifdef LINE_CLIP_EN
  assign in_bounds = !x[WIDTH-1] && !y[WIDTH-1] && (int'(x) < FB_W) && (int'(y) < FB_H);
`else
  assign in_bounds = 1'b1;
`endif
endmodule

// File: rtl/line_raster_engine.sv
// line_raster_engine: all-octant Bresenham line rasteriser driving a framebuffer write port.
// Define LINE_CLIP_EN to suppress off-screen pixels instead of writing wrapped addresses.
module line_raster_engine
  import line_raster_pkg::*;
#(
  parameter int WIDTH   = 13,
  parameter int FB_W    = 640,
  parameter int FB_H    = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   x0,
  input  logic signed [WIDTH-1:0]   y0,
  input  logic signed [WIDTH-1:0]   x1,
  input  logic signed [WIDTH-1:0]   y1,
  input  logic        [COLOR_W-1:0] color_in,
  output logic                      busy,
  output logic                      FB_WE,
  input  logic                      FB_ready,
  output logic        [ADDR_W-1:0]  FB_addr,
  output logic        [COLOR_W-1:0] color_out,
  output logic                      sys_finish
);
  localparam int DW = dw_of(WIDTH);
  localparam int EW = ew_of(WIDTH);
  state_t state_q, state_d;
  logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, x1_q, x1_d, y1_q, y1_d;
  logic signed [WIDTH-1:0] sx_q, sx_d, sy_q, sy_d, nx, ny, fx, fy;
  logic signed [DW-1:0] dx_q, dx_d, dy_q, dy_d, ddx, ddy;
  logic signed [EW-1:0] err_q, err_d;
  logic signed [EW:0] e2;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [ADDR_W-1:0] addr_q, addr_d, frag_addr;
  logic fb_we_q, fb_we_d, busy_q, busy_d, fin_q, fin_d;
  logic step_x, step_y, retire, last, frag_in;

  assign e2 = {err_q, 1'b0};
  assign step_x = e2 >= (EW+1)'(dy_q);
  assign step_y = e2 <= (EW+1)'(dx_q);
  assign nx = step_x ? x_q + sx_q : x_q;
  assign ny = step_y ? y_q + sy_q : y_q;
  // The address unit always looks at the pixel that will be presented next cycle.
  assign fx = (state_q == DRAW) ? nx : x_q;
  assign fy = (state_q == DRAW) ? ny : y_q;
  assign ddx = DW'(x1_q) - DW'(x_q);
  assign ddy = DW'(y1_q) - DW'(y_q);
  assign retire = (state_q == DRAW) && (!fb_we_q || FB_ready);
  assign last = (x_q == x1_q) && (y_q == y1_q);

  line_frag_addr #(
    .WIDTH (WIDTH),
    .FB_W  (FB_W),
    .FB_H  (FB_H),
    .ADDR_W(ADDR_W)
  ) u_frag (
    .x        (fx),
    .y        (fy),
    .addr     (frag_addr),
    .in_bounds(frag_in)
  );

  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    x1_d = x1_q;
    y1_d = y1_q;
    sx_d = sx_q;
    sy_d = sy_q;
    dx_d = dx_q;
    dy_d = dy_q;
    err_d = err_q;
    color_d = color_q;
    addr_d = addr_q;
    fb_we_d = fb_we_q;
    busy_d = busy_q;
    fin_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        busy_d = 1'b1;
        x_d = x0;
        y_d = y0;
        x1_d = x1;
        y1_d = y1;
        color_d = color_in;
      end
      SETUP: begin
        dx_d = ddx[DW-1] ? -ddx : ddx;
        dy_d = ddy[DW-1] ? ddy : -ddy;
        sx_d = ddx[DW-1] ? '1 : WIDTH'(1);
        sy_d = ddy[DW-1] ? '1 : WIDTH'(1);
        err_d = EW'(dx_d) + EW'(dy_d);
        fb_we_d = frag_in;
        addr_d = frag_addr;
        state_d = DRAW;
      end
      DRAW: if (retire) begin
        if (last) begin
          state_d = DONE;
          fb_we_d = 1'b0;
          fin_d = 1'b1;
        end else begin
          x_d = nx;
          y_d = ny;
          err_d = err_q + (step_x ? EW'(dy_q) : '0) + (step_y ? EW'(dx_q) : '0);
          fb_we_d = frag_in;
          addr_d = frag_addr;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
      err_q <= '0;
      color_q <= '0;
      addr_q <= '0;
      fb_we_q <= 1'b0;
      busy_q <= 1'b0;
      fin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      err_q <= err_d;
      color_q <= color_d;
      addr_q <= addr_d;
      fb_we_q <= fb_we_d;
      busy_q <= busy_d;
      fin_q <= fin_d;
    end
  end

  assign busy = busy_q;
  assign FB_WE = fb_we_q;
  assign FB_addr = addr_q;
  assign color_out = color_q;
  assign sys_finish = fin_q;
endmodule

// File: tb/tb_line_raster_engine.sv
// tb_line_raster_engine: directed lines checked against an integer Bresenham pixel-list model.
module tb_line_raster_engine;
  localparam int WIDTH = 13, FB_W = 640, FB_H = 480, ADDR_W = 19, COLOR_W = 1;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, FB_ready = 1'b1;
  logic signed [WIDTH-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [COLOR_W-1:0] color_in = '0;
  logic busy, FB_WE, sys_finish;
  logic [ADDR_W-1:0] FB_addr;
  logic [COLOR_W-1:0] color_out;
  int tests = 0, fails = 0;
  int exp_q[$];
  int wlog[$];
  logic [COLOR_W-1:0] exp_color = '0;
  int wr_cnt = 0, fin_cnt = 0, busy_cyc = 0, stall_cnt = 0, last_addr = 0;
  logic prev_stall = 1'b0, prev_wr = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int w3[4] = '{0, 641, 1282, 1923};

  always #5 clk = ~clk;

  line_raster_engine #(
    .WIDTH(WIDTH), .FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color_in(color_in),
    .busy(busy), .FB_WE(FB_WE), .FB_ready(FB_ready), .FB_addr(FB_addr),
    .color_out(color_out), .sys_finish(sys_finish)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int addr_of(input int x, input int y);
    return (y * FB_W + x) & ((1 << ADDR_W) - 1);
  endfunction

`ifdef LINE_CLIP_EN
  function automatic bit on_screen(input int x, input int y);
    return x >= 0 && x < FB_W && y >= 0 && y < FB_H;
  endfunction
`endif

  // Pixel list straight from the line definition: walk until the end point is reached.
  task automatic plan(input int ax, input int ay, input int bx, input int by);
    int dx, dy, sx, sy, err, e2, x, y;
    dx = bx > ax ? bx - ax : ax - bx;
    dy = by > ay ? ay - by : by - ay;
    sx = bx < ax ? -1 : 1;
    sy = by < ay ? -1 : 1;
    err = dx + dy;
    x = ax;
    y = ay;
    for (int n = 0; n < 20000; n++) begin
`ifdef LINE_CLIP_EN
      if (on_screen(x, y)) exp_q.push_back(addr_of(x, y));
`else
      exp_q.push_back(addr_of(x, y));
`endif
      if (x == bx && y == by) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
      prev_wr = 1'b0;
    end else begin
      if (busy) busy_cyc++;
      if (prev_stall) begin
        chk("hold_we", 32'(FB_WE), 32'd1);
        chk("hold_addr", 32'(FB_addr), 32'(prev_addr));
      end
      if (FB_WE && FB_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_write: addr %0d written with no pixel expected", FB_addr);
        end else chk("write_addr", 32'(FB_addr), 32'(exp_q.pop_front()));
        chk("color", 32'(color_out), 32'(exp_color));
        wr_cnt++;
        last_addr = int'(FB_addr);
        wlog.push_back(int'(FB_addr));
      end
      if (FB_WE && !FB_ready) stall_cnt++;
      if (sys_finish) begin
        fin_cnt++;
        chk("fin_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("fin_we_low", 32'(FB_WE), 32'd0);
        chk("fin_after_write", 32'(prev_wr), 32'd1);
      end
      prev_stall = FB_WE && !FB_ready;
      prev_addr = FB_addr;
      prev_wr = FB_WE && FB_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wr_cnt = 0;
    fin_cnt = 0;
    busy_cyc = 0;
    stall_cnt = 0;
    wlog.delete();
  endtask

  task automatic issue(input int ax, input int ay, input int bx, input int by, input logic [COLOR_W-1:0] c);
    for (int k = 0; k < 100 && busy; k++) tick();
    chk("issue_idle", 32'(busy), 32'd0);
    x0 = WIDTH'(ax);
    y0 = WIDTH'(ay);
    x1 = WIDTH'(bx);
    y1 = WIDTH'(by);
    color_in = c;
    exp_color = c;
    plan(ax, ay, bx, by);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit bp);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      if (bp) FB_ready = pat[k % 4];
      @(negedge clk);
      seen = sys_finish;
      tick();
    end
    FB_ready = 1'b1;
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL wait_done: no sys_finish within 300 cycles");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(FB_WE), 32'd0);
    chk("rst_addr", 32'(FB_addr), 32'd0);
    chk("rst_color", 32'(color_out), 32'd0);
    chk("rst_fin", 32'(sys_finish), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    clr();
    issue(0, 0, 5, 0, 1'b1);
    @(negedge clk);
    chk("t1_setup_busy", 32'(busy), 32'd1);
    chk("t1_setup_we", 32'(FB_WE), 32'd0);
    tick();
    @(negedge clk);
    chk("t1_first_we", 32'(FB_WE), 32'd1);
    chk("t1_first_addr", 32'(FB_addr), 32'd0);
    wait_done(1'b0);
    chk("t1_writes", 32'(wr_cnt), 32'd6);
    chk("t1_last_addr", 32'(last_addr), 32'd5);
    chk("t1_fin_cnt", 32'(fin_cnt), 32'd1);
    chk("t1_busy_cycles", 32'(busy_cyc), 32'd8);

    clr();
    issue(3, 7, 1, 0, 1'b1);
    wait_done(1'b0);
    chk("t2_writes", 32'(wr_cnt), 32'd8);
    chk("t2_last_addr", 32'(last_addr), 32'd1);
    chk("t2_fin_cnt", 32'(fin_cnt), 32'd1);

    clr();
    issue(0, 0, 3, 3, 1'b1);
    wait_done(1'b1);
    chk("t3_writes", 32'(wr_cnt), 32'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) chk("t3_order", 32'(wlog[i]), 32'(w3[i]));
    chk("t3_stalls_seen", 32'(stall_cnt > 0), 32'd1);

    clr();
    issue(10, 10, 10, 10, 1'b1);
    x0 = WIDTH'(0);
    y0 = WIDTH'(0);
    x1 = WIDTH'(5);
    y1 = WIDTH'(0);
    start = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    chk("t4_writes", 32'(wr_cnt), 32'd1);
    chk("t4_addr", 32'(last_addr), 32'd6410);
    chk("t4_fin_cnt", 32'(fin_cnt), 32'd1);
    chk("t4_idle_after_done", 32'(busy), 32'd0);
    clr();
    issue(1, 1, 2, 1, 1'b0);
    chk("t4_accept_after_done", 32'(busy), 32'd1);
    wait_done(1'b0);
    chk("t4b_writes", 32'(wr_cnt), 32'd2);
    chk("t4b_last_addr", 32'(last_addr), 32'd642);

    clr();
    issue(-2, 0, 2, 0, 1'b1);
    wait_done(1'b0);
    chk("t5_fin_cnt", 32'(fin_cnt), 32'd1);
    chk("t5_busy_cycles", 32'(busy_cyc), 32'd7);
    chk("t5_last_addr", 32'(last_addr), 32'd2);
`ifdef LINE_CLIP_EN
    chk("t5_writes", 32'(wr_cnt), 32'd3);
    if (wlog.size() > 0) chk("t5_first_addr", 32'(wlog[0]), 32'd0);
`else
    chk("t5_writes", 32'(wr_cnt), 32'd5);
    if (wlog.size() > 0) chk("t5_first_addr", 32'(wlog[0]), 32'd524286);
`endif

    clr();
    issue(0, 0, 20, 0, 1'b1);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_we", 32'(FB_WE), 32'd0);
    chk("t6_addr", 32'(FB_addr), 32'd0);
    chk("t6_color", 32'(color_out), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_fin", 32'(sys_finish), 32'd0);
    tick();
    reset = 1'b0;
    fin_cnt = 0;
    for (int k = 0; k < 5; k++) tick();
    chk("t6_no_fin", 32'(fin_cnt), 32'd0);
    clr();
    issue(2, 1, 4, 2, 1'b1);
    wait_done(1'b0);
    chk("t6b_writes", 32'(wr_cnt), 32'd3);
    chk("t6b_last_addr", 32'(last_addr), 32'd1284);
    chk("t6b_fin_cnt", 32'(fin_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
